// File: rtl/outport_hex_display.sv
// -----------------------------------------------------------------------------
// outport_hex_display
//
// Display front end for the picoMIPS outport. Each strobed CPU value is
// queued in a small FIFO. Each value stays on the display for at least HOLD
// clocks, so fast program output remains readable. The value shown is driven
// onto a 2-digit, multiplexed, active-low 7-segment hex display.
//
// Ports:
//   clk    in   system clock, rising edge (same clock as the CPU)
//   reset  in   asynchronous, active-low master reset
//   din    in   [n-1:0] value from the CPU outport
//   we     in   capture strobe, sampled on the rising edge
//   shown  out  [n-1:0] value currently on the display
//   count  out  [$clog2(DEPTH):0] FIFO occupancy
//   ovf    out  sticky overflow flag (a strobe arrived while full, no pop)
//   seg    out  [6:0] segments {g,f,e,d,c,b,a}, active-low
//   an     out  [1:0] digit enables, active-low; an[0] low nibble, an[1] high
// -----------------------------------------------------------------------------
module outport_hex_display #(
   parameter int n     = 8,  // data width, two hex digits only
   parameter int DEPTH = 4,  // FIFO entries, power of 2, >= 2
   parameter int HOLD  = 4,  // minimum clocks each value is shown, >= 1
   parameter int SCAN  = 2   // clocks per digit in the scan, >= 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [n-1:0]               din,
   input  logic                       we,
   output logic [n-1:0]               shown,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       ovf,
   output logic [6:0]                 seg,
   output logic [1:0]                 an
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int DW = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam int SW = (SCAN > 1) ? $clog2(SCAN) : 1;

   localparam logic [DW-1:0] DWELL_MAX = DW'(HOLD - 1);
   localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN - 1);
   localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

   // Segment patterns for hex digits 0..F, {g,f,e,d,c,b,a}, active-low.
   function automatic logic [6:0] hex7(input logic [3:0] nib);
      logic [6:0] s;
      // NOTE: every output of combinational code gets a default first, so
      // no path through the case can leave it unassigned and infer a latch.
      s = 7'h7F;
      case (nib)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         4'hF: s = 7'h0E;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   logic [n-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [DW-1:0] dwell;   // clocks the current value has been shown, saturating
   logic [SW-1:0] sc;      // clocks spent on the current digit
   logic          d;       // digit being scanned: 0 = low nibble, 1 = high

   logic pop;
   logic push;
   logic drop;

   // A pop frees a slot on the same edge, so a full FIFO can still accept a
   // value when the dwell period of the head has just ended.
   always_comb begin
      pop  = (dwell == DWELL_MAX) && (count != '0);
      push = we && ((count != FULL_CNT) || pop);
      drop = we && !push;
   end

   // NOTE: the storage array carries no reset; an entry is read only after
   // it has been written, and leaving it out keeps the array a plain RAM.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= din;
      end
   end

   // NOTE: all state updates use non-blocking assignments so every register
   // sees the pre-edge values of the others, matching the hardware.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         shown  <= '0;
         ovf    <= 1'b0;
         dwell  <= DWELL_MAX;   // saturated, so the first value shows promptly
         sc     <= '0;
         d      <= 1'b0;
         seg    <= 7'h7F;
         an     <= 2'b11;
      end else begin
         // Dwell and pop
         if (pop) begin
            shown  <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1'b1;
            dwell  <= '0;
         end else if (dwell != DWELL_MAX) begin
            dwell  <= dwell + 1'b1;
         end

         // Push; pointers wrap naturally because DEPTH is a power of 2
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         if (drop) begin
            ovf <= 1'b1;
         end

         // Digit scan
         if (sc == SCAN_MAX) begin
            sc <= '0;
            d  <= ~d;
         end else begin
            sc <= sc + 1'b1;
         end

         // Registered drive from pre-edge digit select and shown value
         if (d) begin
            an  <= 2'b01;
            seg <= hex7(shown[7:4]);
         end else begin
            an  <= 2'b10;
            seg <= hex7(shown[3:0]);
         end
      end
   end

endmodule

// File: tb/tb_outport_hex_display.sv
// -----------------------------------------------------------------------------
// tb_outport_hex_display
//
// Self-checking bench for outport_hex_display with default parameters.
// A queue-based model tracks what must be displayed. A negedge process
// compares every output against the model on every clock. Directed
// sequences add hand-computed literal expectations. Randomized traffic at
// several strobe densities follows the directed part.
// -----------------------------------------------------------------------------
module tb_outport_hex_display;

   localparam int N     = 8;
   localparam int DEPTH = 4;
   localparam int HOLD  = 4;
   localparam int SCAN  = 2;

   logic         clk;
   logic         reset;
   logic [N-1:0] din;
   logic         we;
   logic [N-1:0] shown;
   logic [2:0]   count;
   logic         ovf;
   logic [6:0]   seg;
   logic [1:0]   an;

   outport_hex_display #(.n(N), .DEPTH(DEPTH), .HOLD(HOLD), .SCAN(SCAN)) dut (
      .clk   (clk),
      .reset (reset),
      .din   (din),
      .we    (we),
      .shown (shown),
      .count (count),
      .ovf   (ovf),
      .seg   (seg),
      .an    (an)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_vec = 0;
   int n_err = 0;
   bit cmp_en = 1'b0;

   logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // Behavioural model: a queue of pending values plus the time since the
   // displayed value last changed and the number of edges since reset.
   logic [7:0] q [$];
   logic [7:0] m_shown;
   bit         m_ovf;
   int         since_show;
   int         edges;
   logic [6:0] m_seg;
   logic [1:0] m_an;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_shown    = '0;
      m_ovf      = 1'b0;
      since_show = HOLD - 1;
      edges      = 0;
      m_seg      = 7'h7F;
      m_an       = 2'b11;
   endtask

   task automatic model_edge(input logic [7:0] v, input logic w);
      bit         pop;
      int         digit;
      logic [3:0] nib;
      // The digit scanned before this edge alternates every SCAN edges.
      digit = (edges / SCAN) % 2;
      nib   = (digit == 1) ? m_shown[7:4] : m_shown[3:0];
      m_seg = hex_tab[nib];
      m_an  = (digit == 1) ? 2'b01 : 2'b10;
      pop   = (since_show >= HOLD - 1) && (q.size() > 0);
      if (pop) begin
         m_shown    = q.pop_front();
         since_show = 0;
      end else begin
         since_show++;
      end
      if (w) begin
         if (q.size() < DEPTH) q.push_back(v);
         else                  m_ovf = 1'b1;
      end
      edges++;
   endtask

   task automatic cycle(input logic [7:0] v, input logic w);
      din = v;
      we  = w;
      @(posedge clk);
      model_edge(v, w);
      #1;
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) cycle(8'h00, 1'b0);
   endtask

   // Compare process: every output against the model, away from the edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("shown", shown, m_shown);
         check("count", count, q.size());
         check("ovf",   ovf,   m_ovf);
         check("seg",   seg,   m_seg);
         check("an",    an,    m_an);
      end
   end

   logic [1:0] an_seq   [5] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b10};
   logic [7:0] burst_v  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
   int         burst_c  [4] = '{1, 1, 2, 3};
   int         pct      [3] = '{10, 45, 90};
   logic [7:0] hist [$];
   logic [7:0] last;

   initial begin
      reset = 1'b1;
      din   = '0;
      we    = 1'b0;
      model_reset();
      #1 reset = 1'b0;
      #2;
      cmp_en = 1'b1;
      // Reset / blank
      check("rst_seg",   seg,   7'h7F);
      check("rst_an",    an,    2'b11);
      check("rst_shown", shown, 8'h00);
      check("rst_count", count, 3'd0);
      check("rst_ovf",   ovf,   1'b0);
      #19 reset = 1'b1;   // release at t=22, clear of the edge at t=25
      for (int i = 0; i < 5; i++) begin
         cycle(8'h00, 1'b0);
         check("scan_an", an, an_seq[i]);
         if (i == 0) check("scan_seg0", seg, 7'h40);
      end

      // Single write, idle beforehand
      cycle(8'h3A, 1'b1);
      check("sw_count1", count, 3'd1);
      cycle(8'h00, 1'b0);
      check("sw_shown", shown, 8'h3A);
      check("sw_count0", count, 3'd0);
      for (int i = 0; i < 5; i++) begin
         cycle(8'h00, 1'b0);
         if (an == 2'b10) check("sw_seg_lo", seg, 7'h08);
         else             check("sw_seg_hi", seg, 7'h30);
      end

      // Dwell burst
      idle(4);
      for (int i = 0; i < 16; i++) begin
         if (i < 4) cycle(burst_v[i], 1'b1);
         else       cycle(8'h00, 1'b0);
         if (i < 4)  check("burst_count", count, burst_c[i]);
         if (i == 1) check("burst_s11", shown, 8'h11);
         if (i == 5) check("burst_s22", shown, 8'h22);
         if (i == 9) check("burst_s33", shown, 8'h33);
         if (i == 13) check("burst_s44", shown, 8'h44);
         check("burst_ovf", ovf, 1'b0);
      end

      // Overflow
      idle(4);
      last = shown;
      for (int i = 0; i < 30; i++) begin
         if (i < 7) cycle(8'(i + 1), 1'b1);
         else       cycle(8'h00, 1'b0);
         if (i == 5) begin
            check("ovf_cnt4", count, 3'd4);
            check("ovf_clr5", ovf, 1'b0);
         end
         if (i == 6) check("ovf_set6", ovf, 1'b1);
         if (shown !== last) begin
            hist.push_back(shown);
            last = shown;
         end
      end
      check("ovf_hist_len", hist.size(), 6);
      for (int i = 0; i < hist.size() && i < 6; i++)
         check("ovf_hist", hist[i], 8'(i + 1));

      // Reset mid-operation with count=3 and ovf=1
      idle(4);
      for (int i = 0; i < 4; i++) cycle(8'hA1 + 8'(i), 1'b1);
      check("mid_pre_count", count, 3'd3);
      check("mid_pre_ovf",   ovf,   1'b1);
      #2 reset = 1'b0;
      model_reset();
      #1;
      check("mid_count", count, 3'd0);
      check("mid_shown", shown, 8'h00);
      check("mid_ovf",   ovf,   1'b0);
      check("mid_seg",   seg,   7'h7F);
      check("mid_an",    an,    2'b11);
      #3 reset = 1'b1;
      cycle(8'h5C, 1'b1);
      cycle(8'h00, 1'b0);
      check("mid_5c", shown, 8'h5C);

      // Scan/decode with F0 displayed
      idle(4);
      cycle(8'hF0, 1'b1);
      idle(2);
      for (int i = 0; i < 8; i++) begin
         cycle(8'h00, 1'b0);
         if (an == 2'b10) check("f0_seg_lo", seg, 7'h40);
         else             check("f0_seg_hi", seg, 7'h0E);
      end

      // Randomized traffic at three strobe densities
      for (int b = 0; b < 3; b++) begin
         for (int i = 0; i < 150; i++) begin
            cycle(8'($urandom_range(0, 255)), ($urandom_range(0, 99) < pct[b]));
         end
         idle(20);
      end

      cmp_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
